// File: rtl/ltssm_pkg.sv
// Shared LTSSM types and timing constants.
package ltssm_pkg;

    localparam int unsigned DETECT_12MS_CYCLES_250MHZ = 3_000_000;

    typedef enum logic [2:0] {
        DETECT_IDLE       = 3'd0,
        DETECT_QUIET      = 3'd1,
        DETECT_ACTIVE     = 3'd2,
        DETECT_RETRY_WAIT = 3'd3,
        DETECT_DONE       = 3'd4
    } detect_sm_e;

endpackage

// File: rtl/ltssm_timeout_timer.sv
// Saturating timeout counter; expired_c pulses on the last enabled count.
module ltssm_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count_q;

    // Holds at LAST instead of wrapping; owner clears on every reuse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_q <= count_q + TW'(1);
        end
    end

    assign expired_c = enable_i && (count_q == LAST);

endmodule

// File: rtl/control_detect.sv
// LTSSM Detect substate controller: Quiet/Active sequencing, PHY receiver
// detection handshake and lane selection ahead of Polling.
module control_detect
    import ltssm_pkg::*;
#(
    parameter int unsigned NUM_LANES      = 1,
    parameter int unsigned TIMEOUT_CYCLES = DETECT_12MS_CYCLES_250MHZ
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 detect_en_i,
    input  logic [NUM_LANES-1:0] rx_elec_idle_i,
    output logic                 rx_det_req_o,
    input  logic                 rx_det_done_i,
    input  logic [NUM_LANES-1:0] rx_det_result_i,
    output logic                 polling_en_o,
    output logic [NUM_LANES-1:0] lanes_active_o,
    output detect_sm_e           detect_state_o
);

    detect_sm_e           state_q, state_d;
    logic                 retry_q, retry_d;
    logic [NUM_LANES-1:0] first_result_q, first_result_d;
    logic [NUM_LANES-1:0] lanes_q, lanes_d;
    logic                 rx_det_req_q;
    logic                 polling_en_q;
    logic                 timer_clear_c;
    logic                 timer_en_c;
    logic                 timer_expired_c;

    assign timer_en_c = (state_q == DETECT_QUIET) || (state_q == DETECT_RETRY_WAIT);

    // Fresh timer on every entry into a timed state, and whenever idle.
    assign timer_clear_c = (state_d == DETECT_IDLE)
                        || (((state_d == DETECT_QUIET) || (state_d == DETECT_RETRY_WAIT))
                            && (state_d != state_q));

    ltssm_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (timer_clear_c),
        .enable_i  (timer_en_c),
        .expired_c (timer_expired_c)
    );

    // Next-state and next-register logic; abort overrides every transition.
    always_comb begin
        state_d        = state_q;
        retry_d        = retry_q;
        first_result_d = first_result_q;
        lanes_d        = lanes_q;

        if ((state_q != DETECT_IDLE) && !detect_en_i) begin
            state_d = DETECT_IDLE;
            retry_d = 1'b0;
            lanes_d = '0;
        end else begin
            unique case (state_q)
                DETECT_IDLE: begin
                    if (detect_en_i) begin
                        state_d = DETECT_QUIET;
                        retry_d = 1'b0;
                    end
                end
                DETECT_QUIET: begin
                    if (timer_expired_c || !(&rx_elec_idle_i)) begin
                        state_d = DETECT_ACTIVE;
                    end
                end
                DETECT_ACTIVE: begin
                    if (rx_det_done_i) begin
                        if (rx_det_result_i == '0) begin
                            state_d = DETECT_QUIET;
                            retry_d = 1'b0;
                        end else if (&rx_det_result_i) begin
                            state_d = DETECT_DONE;
                            lanes_d = rx_det_result_i;
                        end else if (!retry_q) begin
                            state_d        = DETECT_RETRY_WAIT;
                            first_result_d = rx_det_result_i;
                            retry_d        = 1'b1;
                        end else if (rx_det_result_i == first_result_q) begin
                            state_d = DETECT_DONE;
                            lanes_d = rx_det_result_i;
                        end else begin
                            state_d = DETECT_QUIET;
                            retry_d = 1'b0;
                        end
                    end
                end
                DETECT_RETRY_WAIT: begin
                    if (timer_expired_c) begin
                        state_d = DETECT_ACTIVE;
                    end
                end
                DETECT_DONE: begin
                    state_d = DETECT_DONE;
                end
                default: begin
                    state_d = DETECT_IDLE;
                    retry_d = 1'b0;
                    lanes_d = '0;
                end
            endcase
        end
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= DETECT_IDLE;
            retry_q        <= 1'b0;
            first_result_q <= '0;
            lanes_q        <= '0;
            rx_det_req_q   <= 1'b0;
            polling_en_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            retry_q        <= retry_d;
            first_result_q <= first_result_d;
            lanes_q        <= lanes_d;
            rx_det_req_q   <= (state_d == DETECT_ACTIVE);
            polling_en_q   <= (state_d == DETECT_DONE);
        end
    end

    assign rx_det_req_o   = rx_det_req_q;
    assign polling_en_o   = polling_en_q;
    assign lanes_active_o = lanes_q;
    assign detect_state_o = state_q;

endmodule

// File: tb/tb_control_detect.sv
// Directed self-checking bench for control_detect (4 lanes, 8-cycle timeout).
module tb_control_detect;
    import ltssm_pkg::*;

    localparam int unsigned NL = 4;
    localparam int unsigned TO = 8;

    logic          clk_i;
    logic          rst_ni;
    logic          detect_en_i;
    logic [NL-1:0] rx_elec_idle_i;
    logic          rx_det_req_o;
    logic          rx_det_done_i;
    logic [NL-1:0] rx_det_result_i;
    logic          polling_en_o;
    logic [NL-1:0] lanes_active_o;
    detect_sm_e    detect_state_o;

    int checks   = 0;
    int failures = 0;

    control_detect #(
        .NUM_LANES      (NL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .detect_en_i     (detect_en_i),
        .rx_elec_idle_i  (rx_elec_idle_i),
        .rx_det_req_o    (rx_det_req_o),
        .rx_det_done_i   (rx_det_done_i),
        .rx_det_result_i (rx_det_result_i),
        .polling_en_o    (polling_en_o),
        .lanes_active_o  (lanes_active_o),
        .detect_state_o  (detect_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input detect_sm_e st, input logic req,
                             input logic pol, input logic [NL-1:0] lanes);
        check({tag, ".state"}, 32'(detect_state_o), 32'(st));
        check({tag, ".req"},   32'(rx_det_req_o),   32'(req));
        check({tag, ".pol"},   32'(polling_en_o),   32'(pol));
        check({tag, ".lanes"}, 32'(lanes_active_o), 32'(lanes));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic pulse_done(input logic [NL-1:0] res);
        rx_det_done_i   = 1'b1;
        rx_det_result_i = res;
        step(1);
        rx_det_done_i   = 1'b0;
        rx_det_result_i = '0;
    endtask

    // Enable, then drop idle on lane 2 in the first QUIET cycle.
    task automatic go_active_fast();
        detect_en_i    = 1'b1;
        rx_elec_idle_i = 4'hF;
        step(1);
        rx_elec_idle_i = 4'b1011;
        step(1);
        rx_elec_idle_i = 4'hF;
    endtask

    initial begin
        rst_ni          = 1'b0;
        detect_en_i     = 1'b0;
        rx_elec_idle_i  = 4'hF;
        rx_det_done_i   = 1'b0;
        rx_det_result_i = '0;
        step(2);
        check_all("reset", DETECT_IDLE, 1'b0, 1'b0, 4'h0);
        rst_ni = 1'b1;
        step(1);

        // Pure timeout: 8 QUIET cycles then ACTIVE.
        detect_en_i = 1'b1;
        step(1);
        check_all("quiet_entry", DETECT_QUIET, 1'b0, 1'b0, 4'h0);
        step(TO - 1);
        check_all("quiet_last", DETECT_QUIET, 1'b0, 1'b0, 4'h0);
        step(1);
        check_all("timeout_active", DETECT_ACTIVE, 1'b1, 1'b0, 4'h0);

        // No receivers: back to QUIET, then a full timeout again.
        pulse_done(4'h0);
        check_all("zero_quiet", DETECT_QUIET, 1'b0, 1'b0, 4'h0);
        step(TO - 1);
        check("zero_quiet_hold", 32'(detect_state_o), 32'(DETECT_QUIET));
        step(1);
        check_all("zero_retimeout", DETECT_ACTIVE, 1'b1, 1'b0, 4'h0);

        // Partial, wait (idle drop ignored), matching partial -> DONE.
        pulse_done(4'b0011);
        check_all("partial_wait", DETECT_RETRY_WAIT, 1'b0, 1'b0, 4'h0);
        rx_elec_idle_i = 4'b0000;
        step(TO - 1);
        check("retry_ignores_idle", 32'(detect_state_o), 32'(DETECT_RETRY_WAIT));
        rx_elec_idle_i = 4'hF;
        step(1);
        check_all("retry_active", DETECT_ACTIVE, 1'b1, 1'b0, 4'h0);
        pulse_done(4'b0011);
        check_all("retry_match_done", DETECT_DONE, 1'b0, 1'b1, 4'b0011);
        step(3);
        check_all("done_hold", DETECT_DONE, 1'b0, 1'b1, 4'b0011);

        // Abort from DONE, then a stray done pulse.
        detect_en_i = 1'b0;
        step(1);
        check_all("abort_done", DETECT_IDLE, 1'b0, 1'b0, 4'h0);
        pulse_done(4'hF);
        check_all("stray_done", DETECT_IDLE, 1'b0, 1'b0, 4'h0);

        // Idle exit in QUIET cycle 3; done in first ACTIVE cycle with all lanes.
        detect_en_i = 1'b1;
        step(1);
        step(3);
        check("quiet_c3", 32'(detect_state_o), 32'(DETECT_QUIET));
        rx_elec_idle_i = 4'b1011;
        step(1);
        rx_elec_idle_i = 4'hF;
        check_all("idle_exit_active", DETECT_ACTIVE, 1'b1, 1'b0, 4'h0);
        pulse_done(4'b1111);
        check_all("all_lanes_done", DETECT_DONE, 1'b0, 1'b1, 4'b1111);

        // Abort from ACTIVE.
        detect_en_i = 1'b0;
        step(1);
        check("abort_to_idle", 32'(detect_state_o), 32'(DETECT_IDLE));
        go_active_fast();
        check("fast_active", 32'(detect_state_o), 32'(DETECT_ACTIVE));
        detect_en_i = 1'b0;
        step(1);
        check_all("abort_active", DETECT_IDLE, 1'b0, 1'b0, 4'h0);
        pulse_done(4'b0011);
        check_all("stray_done2", DETECT_IDLE, 1'b0, 1'b0, 4'h0);

        // Partial then differing partial -> QUIET.
        go_active_fast();
        pulse_done(4'b0011);
        check("mis_wait", 32'(detect_state_o), 32'(DETECT_RETRY_WAIT));
        step(TO);
        check("mis_active", 32'(detect_state_o), 32'(DETECT_ACTIVE));
        pulse_done(4'b0001);
        check_all("mismatch_quiet", DETECT_QUIET, 1'b0, 1'b0, 4'h0);

        // Retry flag was cleared: a fresh partial goes to RETRY_WAIT again.
        rx_elec_idle_i = 4'b1110;
        step(1);
        rx_elec_idle_i = 4'hF;
        pulse_done(4'b0110);
        check("retry_cleared", 32'(detect_state_o), 32'(DETECT_RETRY_WAIT));

        // Async reset mid-RETRY_WAIT, no clock edge needed.
        step(2);
        #1;
        rst_ni = 1'b0;
        #1;
        check_all("async_reset", DETECT_IDLE, 1'b0, 1'b0, 4'h0);
        step(1);
        #2;
        rst_ni = 1'b1;
        step(1);
        check_all("post_reset_quiet", DETECT_QUIET, 1'b0, 1'b0, 4'h0);
        step(TO - 1);
        check("post_reset_hold", 32'(detect_state_o), 32'(DETECT_QUIET));
        step(1);
        check_all("post_reset_active", DETECT_ACTIVE, 1'b1, 1'b0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
